// File: rtl/shift_seq_arbiter_if.sv
// Request/response bundle between two client blocks and the shift sequencer.
// The sequencer takes the slave side; whoever drives the requests and
// consumes results takes the master side.
interface shift_seq_arbiter_if #(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_AMT  = 3
);
  logic                  req0_valid;
  logic [NBITS_DATA-1:0] req0_data;
  logic [NBITS_AMT-1:0]  req0_amt;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [NBITS_DATA-1:0] req1_data;
  logic [NBITS_AMT-1:0]  req1_amt;
  logic                  req1_ready;
  logic                  res_valid;
  logic [NBITS_DATA-1:0] res_data;
  logic                  res_id;
  logic                  res_ready;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_data, req0_amt,
    input  req1_valid, req1_data, req1_amt,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, busy
  );

  modport master (
    output req0_valid, req0_data, req0_amt,
    output req1_valid, req1_data, req1_amt,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/shift_seq_arbiter.sv
// Two-requester arbiter and sequencer for the one-bit-per-cycle arithmetic
// shift-right datapath.
//
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration between the
// two requesters; otherwise requester 0 has fixed priority.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; grants one valid requester and latches its operands
// SHIFT | one arithmetic right shift per cycle until the count runs out
// DONE  | result held on res_* until the consumer takes it
module shift_seq_arbiter #(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_AMT  = 3
) (
  input logic                 clk,
  input logic                 reset,
  shift_seq_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                        state_q, state_d;
  logic signed [NBITS_DATA-1:0]  data_q, data_d;
  logic [NBITS_AMT-1:0]          cnt_q, cnt_d;
  logic                          id_q, id_d;
  logic                          grant;
  logic                          acc0, acc1;
`ifdef SHIFT_ARB_RR_EN
  // Last granted requester only matters when arbitration is round-robin.
  logic                          last_q, last_d;
`endif

  // Pick which requester would be served if the block is idle.
  always_comb begin
`ifdef SHIFT_ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) grant = ~last_q;
    else                                  grant = ~bus.req0_valid;
`else
    grant = ~bus.req0_valid;
`endif
  end

  // Readies are gated by reset so nothing looks accepted while held in reset.
  assign acc0 = reset && (state_q == IDLE) && !grant && bus.req0_valid;
  assign acc1 = reset && (state_q == IDLE) &&  grant && bus.req1_valid;

  assign bus.req0_ready = acc0;
  assign bus.req1_ready = acc1;
  assign bus.res_valid  = (state_q == DONE);
  assign bus.res_data   = data_q;
  assign bus.res_id     = id_q;
  assign bus.busy       = (state_q != IDLE);

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
`ifdef SHIFT_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (acc0 || acc1) begin
          data_d = grant ? bus.req1_data : bus.req0_data;
          cnt_d  = grant ? bus.req1_amt  : bus.req0_amt;
          id_d   = grant;
`ifdef SHIFT_ARB_RR_EN
          last_d = grant;
`endif
          if ((grant ? bus.req1_amt : bus.req0_amt) == '0) state_d = DONE;
          else                                               state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = data_q >>> 1;
        cnt_d  = cnt_q - 1'b1;
        // A zero count can't reach SHIFT, but treat it as the last shift too.
        if (cnt_q == NBITS_AMT'(1) || cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
`ifdef SHIFT_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
`ifdef SHIFT_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule
